// File: rtl/pdm_word_decimator.sv
// Boxcar decimator for packed PDM words: popcount each word, sum a window of
// words into a saturated signed PCM sample, and buffer samples in a FWFT FIFO.
module pdm_word_decimator #(
  parameter int WORD_LENGTH      = 16,
  parameter int WORDS_PER_SAMPLE = 4,
  parameter int SAMPLE_WIDTH     = 12,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [WORD_LENGTH-1:0]         word_i,
  input  logic                           word_valid_i,
  output logic signed [SAMPLE_WIDTH-1:0] sample_o,
  output logic                           sample_valid_o,
  input  logic                           sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
  output logic                           overflow_o
);

  localparam int PC_W       = $clog2(WORD_LENGTH + 1);
  localparam int FULL_SCALE = WORD_LENGTH * WORDS_PER_SAMPLE;
  localparam int ACC_W      = $clog2(FULL_SCALE + 1);
  localparam int RAW_W      = ACC_W + 2;
  localparam int CNT_W      = (WORDS_PER_SAMPLE > 1) ? $clog2(WORDS_PER_SAMPLE) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = PTR_W + 1;
  localparam int SMAX       = (2 ** (SAMPLE_WIDTH - 1)) - 1;
  localparam int SMIN       = -(2 ** (SAMPLE_WIDTH - 1));
  localparam logic signed [RAW_W-1:0] FULL_RAW = RAW_W'(FULL_SCALE);

  function automatic logic [PC_W-1:0] popcount(input logic [WORD_LENGTH-1:0] w);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WORD_LENGTH; i++) n = n + PC_W'(w[i]);
    return n;
  endfunction

  function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(input logic signed [RAW_W-1:0] r);
    int rv;
    rv = int'(r);
    if (rv > SMAX)      return SAMPLE_WIDTH'(SMAX);
    else if (rv < SMIN) return SAMPLE_WIDTH'(SMIN);
    else                return SAMPLE_WIDTH'(rv);
  endfunction

  // Stage 1: popcount of the incoming word
  logic [PC_W-1:0] pc_p1_q;
  logic            vld_p1_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_p1_q  <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= word_valid_i;
      if (word_valid_i) pc_p1_q <= popcount(word_i);
    end
  end

  // Stage 2: window accumulation, sample formation and FIFO push
  logic [ACC_W-1:0]               acc_q, acc_d, sum_p1;
  logic [CNT_W-1:0]               word_cnt_q, word_cnt_d;
  logic                           close_p1;
  logic signed [RAW_W-1:0]        raw_p1;
  logic signed [SAMPLE_WIDTH-1:0] push_val;

  assign sum_p1   = acc_q + ACC_W'(pc_p1_q);
  assign close_p1 = vld_p1_q && (word_cnt_q == CNT_W'(WORDS_PER_SAMPLE - 1));
  // Ones minus zeros over the window equals 2*ones - total bits.
  assign raw_p1   = $signed({1'b0, sum_p1, 1'b0}) - FULL_RAW;
  assign push_val = saturate(raw_p1);

  always_comb begin
    acc_d      = acc_q;
    word_cnt_d = word_cnt_q;
    if (vld_p1_q) begin
      if (close_p1) begin
        acc_d      = '0;
        word_cnt_d = '0;
      end else begin
        acc_d      = sum_p1;
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      acc_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Output FIFO, first-word-fall-through
  logic signed [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              empty, full, pop, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FCNT_W'(FIFO_DEPTH));
  assign pop     = !empty && sample_ready_i;
  // A full FIFO still takes the new sample when the head leaves on the same edge.
  assign push_ok = close_p1 && (!full || pop);

  always_comb begin
    wr_d    = wr_q + PTR_W'(push_ok);
    rd_d    = rd_q + PTR_W'(pop);
    count_d = count_q + FCNT_W'(push_ok) - FCNT_W'(pop);
    ovf_d   = ovf_q || (close_p1 && full && !pop);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mem[wr_q] <= push_val;
  end

  assign sample_o       = empty ? '0 : mem[rd_q];
  assign sample_valid_o = !empty;
  assign fifo_count_o   = count_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_pdm_word_decimator.sv
// Randomized scoreboard bench for pdm_word_decimator: a window/FIFO reference
// model predicts samples for a 12-bit instance and a saturating 6-bit instance.
module tb_pdm_word_decimator;
  localparam int WL = 16, WPS = 4, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1, word_valid_i = 1'b0, sample_ready_i = 1'b0;
  logic [15:0] word_i = '0;
  logic signed [11:0] sample_o;
  logic        sample_valid_o, overflow_o;
  logic [3:0]  fifo_count_o;
  logic signed [5:0] s6_o;
  logic        v6_o, ovf6_o;
  logic [3:0]  c6_o;

  pdm_word_decimator #(.WORD_LENGTH(16), .WORDS_PER_SAMPLE(4), .SAMPLE_WIDTH(12), .FIFO_DEPTH(8)) dut (
    .clock_i(clk), .reset_i(reset_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o));

  pdm_word_decimator #(.WORD_LENGTH(16), .WORDS_PER_SAMPLE(4), .SAMPLE_WIDTH(6), .FIFO_DEPTH(8)) dut6 (
    .clock_i(clk), .reset_i(reset_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .sample_o(s6_o), .sample_valid_o(v6_o), .sample_ready_i(sample_ready_i),
    .fifo_count_o(c6_o), .overflow_o(ovf6_o));

  typedef struct { int v12; int v6; int due; } exp_t;
  exp_t pend[$];
  exp_t mq[$];

  int total = 0, bad = 0;
  int edge_n = 0;
  int win_cnt = 0, win_ones = 0;
  bit rst_next = 1'b1, pop_next = 1'b0, movf = 1'b0;

  always @(posedge clk) edge_n++;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic int clampv(int raw, int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    if (raw > hi) return hi;
    if (raw < lo) return lo;
    return raw;
  endfunction

  // A sample is the signed difference of ones and zeros over WPS words.
  task automatic step(bit v, logic [15:0] w, bit r);
    int raw;
    exp_t e;
    @(posedge clk); #1;
    reset_i        = 1'b0;
    word_valid_i   = v;
    word_i         = v ? w : 16'($urandom);
    sample_ready_i = r;
    if (v) begin
      win_ones += $countones(w);
      win_cnt++;
      if (win_cnt == WPS) begin
        raw   = 2 * win_ones - WL * WPS;
        e.v12 = clampv(raw, 12);
        e.v6  = clampv(raw, 6);
        e.due = edge_n + 2;
        pend.push_back(e);
        win_cnt  = 0;
        win_ones = 0;
      end
    end
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_i        = 1'b1;
    word_valid_i   = 1'b0;
    sample_ready_i = 1'b0;
    win_cnt        = 0;
    win_ones       = 0;
    @(posedge clk); #1;
  endtask

  task automatic probe(string name, int exp_cnt, int exp_ovf);
    @(negedge clk); #1;
    chk({name, "_count"}, int'(fifo_count_o), exp_cnt);
    chk({name, "_ovf"}, int'(overflow_o), exp_ovf);
  endtask

  // Monitor: applies the edge just passed to the FIFO model, then compares.
  always @(negedge clk) begin
    bit   was_full;
    exp_t e;
    if (rst_next) begin
      mq.delete();
      pend.delete();
      movf = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (pop_next) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        e = pend.pop_front();
        if (was_full && !pop_next) movf = 1'b1;
        else mq.push_back(e);
      end
    end
    chk("valid", int'(sample_valid_o), int'(mq.size() != 0));
    chk("count", int'(fifo_count_o), mq.size());
    chk("overflow", int'(overflow_o), int'(movf));
    chk("valid6", int'(v6_o), int'(mq.size() != 0));
    chk("count6", int'(c6_o), mq.size());
    chk("overflow6", int'(ovf6_o), int'(movf));
    if (mq.size() != 0) begin
      chk("sample", int'(sample_o), mq[0].v12);
      chk("sample6", int'(s6_o), mq[0].v6);
    end
    rst_next = reset_i;
    pop_next = !reset_i && (mq.size() != 0) && sample_ready_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [15:0] pat [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                            16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                            16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};

  initial begin
    do_reset();
    @(negedge clk); #1;
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_valid", int'(sample_valid_o), 0);
    probe("rst", 0, 0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'hFFFF, 1'b1);
      idle(99, 1'b1);
    end

    for (int i = 0; i < 12; i++) step(1'b1, pat[i], 1'b1);
    idle(6, 1'b1);

    for (int i = 0; i < 32; i++) step(1'b1, 16'hFFFF, 1'b1);
    idle(6, 1'b1);

    for (int i = 0; i < 40; i++) step(1'b1, 16'hFFFF, 1'b0);
    idle(4, 1'b0);
    probe("hold", 8, 1);
    chk("hold_sample", int'(sample_o), 64);
    idle(20, 1'b1);
    probe("drain", 0, 1);

    do_reset();
    for (int i = 0; i < 35; i++) step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    idle(3, 1'b0);
    probe("full_pop", 8, 0);
    idle(12, 1'b1);

    do_reset();
    step(1'b1, 16'hFFFF, 1'b1);
    step(1'b1, 16'hFFFF, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0000, 1'b1);
    idle(6, 1'b1);

    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_word_decimator.md
Name: pdm_word_decimator

Overview:
- Consumes the 16-bit packed PDM words produced by the microphone deserializer (one-cycle done pulse plus data word).
- Converts each word to a ones-count, then sums WORDS_PER_SAMPLE consecutive words into one signed PCM sample (ones minus zeros, i.e. a boxcar decimator).
- Buffers finished samples in a small FIFO with a valid/ready interface for the downstream audio consumer (filter, PWM output or recorder).

Parameters:
- WORD_LENGTH, 16, width of the incoming PDM word; all bits are PDM samples.
- WORDS_PER_SAMPLE, 4, words summed per output sample; legal range 1..256.
- SAMPLE_WIDTH, 12, width of the signed two's-complement output sample.
- FIFO_DEPTH, 8, output sample buffer entries; power of two, at least 2.

Ports:
- clock_i  input  1  system clock, 100 MHz.
- reset_i  input  1  synchronous, active-high reset.
- word_i  input  WORD_LENGTH  packed PDM word from the deserializer.
- word_valid_i  input  1  single-cycle strobe; word_i is valid in the same cycle.
- sample_o  output  SAMPLE_WIDTH  signed PCM sample at the FIFO head.
- sample_valid_o  output  1  FIFO not empty.
- sample_ready_i  input  1  consumer accepts sample_o when high together with sample_valid_o.
- fifo_count_o  output  clog2(FIFO_DEPTH)+1  number of samples currently buffered.
- overflow_o  output  1  sticky flag: a completed sample was dropped.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clock_i, reset_i). All state updates on the rising edge of clock_i.
- Reset values: sample_o=0, sample_valid_o=0, fifo_count_o=0, overflow_o=0. Reset also clears the word counter, the accumulator and the pipeline register.
- Reset mid-window: the partial sum is discarded and the next word starts a fresh window.
- Stage 1, popcount: on an edge where word_valid_i=1, register pc = number of ones in word_i (0..WORD_LENGTH) and set pc_valid=1; otherwise pc_valid=0.
- Stage 2, accumulate: on an edge with pc_valid=1, acc += pc and word_cnt += 1.
  - When word_cnt reaches WORDS_PER_SAMPLE-1 before the add, this word closes the window.
  - The sample raw = 2*(acc+pc) - WORD_LENGTH*WORDS_PER_SAMPLE is pushed to the FIFO.
  - acc and word_cnt clear to 0 on the same edge.
- Arithmetic:
  - acc width is clog2(WORD_LENGTH*WORDS_PER_SAMPLE+1).
  - raw is computed signed with 2 guard bits and has range ±WORD_LENGTH*WORDS_PER_SAMPLE.
  - raw saturates to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; no wrap.
- Latency: a closing word strobed in cycle t appears at the FIFO head with sample_valid_o=1 in cycle t+2, if the FIFO was empty.
- Throughput: word_valid_i may be asserted every cycle; no input stalls and no backpressure to the deserializer.
- FIFO:
  - Pop occurs on an edge with sample_valid_o && sample_ready_i.
  - sample_o is the head entry; it is registered or first-word-fall-through, and stable while sample_valid_o=1 and sample_ready_i=0.
  - Simultaneous push and pop when non-empty: both occur and the count is unchanged.
  - Push when full with a pop in the same edge: accepted.
  - Push when full with no pop: the sample is dropped, overflow_o is set to 1 and held until reset, and the FIFO contents are unchanged.
  - sample_ready_i while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count_o is exact every cycle.
- word_i is ignored whenever word_valid_i=0.

Test Plan:
- Reset, then 4 strobes of word_i=16'hFFFF spaced 100 cycles apart, sample_ready_i=1 -> exactly one sample with sample_o=+64 (12'h040), sample_valid_o high 2 cycles after the 4th strobe, for one cycle.
- 4 words of 16'h0000 -> sample -64 (12'hFC0). 4 words of 16'hAAAA -> 0. Words 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF (ones = 4+8+12+16 = 40) -> 2*40-64 = +16.
- Back-to-back strobes every cycle for 32 words of 16'hFFFF with sample_ready_i=1 -> 8 samples of +64, no overflow, fifo_count_o never exceeds 2.
- sample_ready_i=0, 40 words of 16'hFFFF (10 samples) -> fifo_count_o reaches 8, overflow_o=1 after the 9th sample, sample_o stays +64. Then assert ready -> exactly 8 pops, count returns to 0, overflow_o remains 1.
- Full FIFO with sample_ready_i=1 on the same edge a 9th sample completes -> push accepted, count stays 8, overflow_o=0.
- Reset after 2 of 4 words, then 4 words of 16'h0000 -> single sample -64 (partial window discarded).
- Saturation, with SAMPLE_WIDTH=6 and WORDS_PER_SAMPLE=4: all ones -> +31; all zeros -> -32.
